// File: rtl/matrix_res_serializer.sv
// Serializes one packed ELEM_W*N_ELEM matrix word into N_ELEM row-major element beats
// with valid/ready on both sides; back-to-back words stream without bubbles.
module matrix_res_serializer #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 4,
  parameter int CNT_W  = 16,
  localparam int DATA_W = ELEM_W * N_ELEM,
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  mat_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sh;
  logic [IDX_W-1:0]  idx;
  logic              at_last, in_xfer, out_xfer;

  assign at_last  = (idx == LAST_IDX);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_xfer) state_nxt = SEND;
      SEND: if (out_xfer && at_last && !in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is held low while rst is asserted so nothing is captured in reset.
  always_comb begin
    out_valid = (state == SEND);
    out_last  = (state == SEND) & at_last;
    in_ready  = ~rst & ((state == IDLE) | ((state == SEND) & at_last & out_ready));
  end

  // The head element always sits in the MSBs; shifting after the final beat leaves zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      idx       <= '0;
      mat_count <= '0;
    end else begin
      if (out_xfer && at_last) mat_count <= mat_count + 1'b1;
      if (in_xfer) begin
        sh  <= in_data;
        idx <= '0;
      end else if (out_xfer) begin
        sh  <= sh << ELEM_W;
        idx <= at_last ? '0 : idx + 1'b1;
      end
    end
  end

  assign out_data = sh[DATA_W-1 -: ELEM_W];
  assign out_idx  = idx;

endmodule

// File: tb/tb_matrix_res_serializer.sv
// Scoreboard bench for matrix_res_serializer: directed reset/single/backpressure/
// back-to-back/abort cases plus randomized traffic against a queue-based model.
module tb_matrix_res_serializer;
  localparam int ELEM_W = 8;
  localparam int N_ELEM = 4;
  localparam int CNT_W  = 4;  // narrow counter so wrap-around occurs within the run
  localparam int DATA_W = ELEM_W * N_ELEM;

  logic              clk = 0;
  logic              rst = 1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 0;
  logic              in_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 0;
  logic              out_last;
  logic [1:0]        out_idx;
  logic [CNT_W-1:0]  mat_count;

  matrix_res_serializer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx), .mat_count(mat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  int   pops    = 0;
  int   mode    = 0;  // 0: out_ready=1, 1: pattern 1,0,0, 2: random
  int   pat     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1;
      1: begin out_ready = (pat % 3 == 0); pat++; end
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: the queue holds the remaining elements of the matrix in flight (plus the
  // next one when back-to-back), so ready/valid expectations follow from its size.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mat_count", mat_count, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      q.delete();
      exp_cnt = 0;
    end else begin
      logic exp_v, exp_r;
      exp_v = (q.size() != 0);
      exp_r = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, exp_r);
      chk("mat_count", mat_count, exp_cnt % (1 << CNT_W));
      if (exp_v) begin
        chk("out_data", out_data, q[0].d);
        chk("out_idx", out_idx, q[0].i);
        chk("out_last", out_last, q[0].l);
      end
      if (exp_v && out_ready) begin
        exp_t e;
        e = q.pop_front();
        pops++;
        if (e.l) exp_cnt++;
      end
      if (in_valid && exp_r) begin
        for (int k = 0; k < N_ELEM; k++) begin
          exp_t e;
          e.d = 8'((in_data >> (ELEM_W * (N_ELEM - 1 - k))) & 32'hFF);
          e.i = 2'(k);
          e.l = (k == N_ELEM - 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    int n;
    in_data  = w;
    in_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_data  = DATA_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    in_valid = 1;
    in_data  = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    mode = 0;
    send(32'h13162B32);
    drain();

    mode = 1; pat = 0;
    send(32'h13162B32);
    drain();

    mode = 0;
    send(32'h01020304);
    send(32'h05060708);
    drain();

    // Abort after two elements of a matrix; outputs must clear asynchronously.
    begin
      int base, n;
      base = pops;
      send(32'hA1A2A3A4);
      n = 0;
      while (pops < base + 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("abort_timeout", 1, 0);
      #2 rst = 1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_last", out_last, 0);
      chk("abort_mat_count", mat_count, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 0;
      send(32'h11223344);
      drain();
    end

    mode = 2;
    for (int m = 0; m < 60; m++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      send(DATA_W'($urandom));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
